// File: rtl/detonator_ctrl_n.sv
// Purpose : parametrised code-entry detonator controller. Each raw key has its
//           own debounce. Entered digits are checked against CODE. Failed
//           attempts are counted, and enough of them trigger a timed lockout.
// Latency : a key held high for KEY_CNT_MAX samples acts on the following edge.
// Backpressure: none; simultaneous key pulses are resolved by fixed priority,
//           and the losing pulses are dropped.
//
// Ports:
//   clk, rst                       rising-edge clock, synchronous active-high reset
//   wait_t, setup, ready, fire,
//   sure, confirm                  raw active-high keys (debounced internally)
//   A[DIGIT_W]                     digit switches, captured on an accepted confirm
//   lt / bt / rt                   armed / error(+lockout) / fire lamps
//   state[3]                       IDLE=0 ENTRY=1 ARMED=2 FIRE=3 ERROR=4 LOCKOUT=5
//   dig_cnt                        number of digits entered
//   entry                          entered digits, left-aligned, first digit in the MS slot
//   fails[4]                       failed attempts since last success/lockout/reset
//
// Build option: define DETONATOR_LOCKOUT_EN to enable fail counting and the
// LOCKOUT state. Without it, every fail goes to ERROR and fails reads 0.
module detonator_ctrl_n #(
    parameter int                          DIGITS      = 4,
    parameter int                          DIGIT_W     = 4,
    parameter logic [DIGITS*DIGIT_W-1:0]   CODE        = 16'h2580,
    parameter int                          KEY_CNT_MAX = 4,
    parameter int                          MAX_TRIES   = 3,
    parameter int                          LOCK_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wait_t,
    input  logic                           setup,
    input  logic                           ready,
    input  logic                           fire,
    input  logic                           sure,
    input  logic                           confirm,
    input  logic [DIGIT_W-1:0]             A,
    output logic                           lt,
    output logic                           bt,
    output logic                           rt,
    output logic [2:0]                     state,
    output logic [$clog2(DIGITS+1)-1:0]    dig_cnt,
    output logic [DIGITS*DIGIT_W-1:0]      entry,
    output logic [3:0]                     fails
);

    localparam int CW   = $clog2(DIGITS+1);
    localparam int KW   = $clog2(KEY_CNT_MAX+1);
    localparam int NKEY = 6;

    // Key index order doubles as priority order: lower index wins.
    localparam int K_SETUP   = 0;
    localparam int K_WAIT    = 1;
    localparam int K_FIRE    = 2;
    localparam int K_SURE    = 3;
    localparam int K_CONFIRM = 4;
    localparam int K_READY   = 5;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ENTRY   = 3'd1;
    localparam logic [2:0] S_ARMED   = 3'd2;
    localparam logic [2:0] S_FIRE    = 3'd3;
    localparam logic [2:0] S_ERROR   = 3'd4;
`ifdef DETONATOR_LOCKOUT_EN
    localparam logic [2:0] S_LOCKOUT = 3'd5;
    localparam int         TW        = $clog2(LOCK_CYCLES+1);
`endif

    // ------------------------------------------------------------------
    // Debounce: one saturating counter per key. The pulse is registered on
    // the edge where the counter reaches KEY_CNT_MAX, so it is visible in the
    // following cycle and the FSM acts one edge later.
    // ------------------------------------------------------------------
    logic [NKEY-1:0] key_raw;
    logic [KW-1:0]   key_cnt_q [NKEY];
    logic [KW-1:0]   key_cnt_d [NKEY];
    logic [NKEY-1:0] key_pls_q;
    logic [NKEY-1:0] key_pls_d;

    assign key_raw = {ready, confirm, sure, fire, wait_t, setup};

    always_comb begin
        for (int i = 0; i < NKEY; i++) begin
            key_cnt_d[i] = '0;
            key_pls_d[i] = 1'b0;
            if (key_raw[i]) begin
                if (key_cnt_q[i] == KW'(KEY_CNT_MAX)) begin
                    key_cnt_d[i] = key_cnt_q[i];
                end else begin
                    key_cnt_d[i] = key_cnt_q[i] + KW'(1);
                end
                key_pls_d[i] = (key_cnt_q[i] == KW'(KEY_CNT_MAX - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NKEY; i++) begin
                key_cnt_q[i] <= '0;
            end
            key_pls_q <= '0;
        end else begin
            for (int i = 0; i < NKEY; i++) begin
                key_cnt_q[i] <= key_cnt_d[i];
            end
            key_pls_q <= key_pls_d;
        end
    end

    // Keep only the highest-priority pulse. The descending scan lets the
    // lowest set index overwrite the others.
    logic [NKEY-1:0] key_win;

    always_comb begin
        key_win = '0;
        for (int i = NKEY - 1; i >= 0; i--) begin
            if (key_pls_q[i]) begin
                key_win    = '0;
                key_win[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Main FSM
    // ------------------------------------------------------------------
    logic [2:0]                  state_q, state_d;
    logic [CW-1:0]               dig_cnt_q, dig_cnt_d;
    logic [DIGITS*DIGIT_W-1:0]   entry_q, entry_d;
    logic                        do_fail;
`ifdef DETONATOR_LOCKOUT_EN
    logic [3:0]                  fails_q, fails_d;
    logic [3:0]                  fails_inc;
    logic [TW-1:0]               lock_q, lock_d;
`endif

    always_comb begin
        state_d   = state_q;
        dig_cnt_d = dig_cnt_q;
        entry_d   = entry_q;
        do_fail   = 1'b0;
`ifdef DETONATOR_LOCKOUT_EN
        fails_d   = fails_q;
        lock_d    = lock_q;
        fails_inc = fails_q + 4'd1;
`endif
        case (state_q)
            S_IDLE: begin
                if (key_win[K_READY]) begin
                    state_d   = S_ENTRY;
                    dig_cnt_d = '0;
                    entry_d   = '0;
                end
            end
            S_ENTRY: begin
                // setup is deliberately a no-op here: it wins priority and
                // swallows any simultaneous key.
                if (key_win[K_WAIT]) begin
                    state_d = S_IDLE;
                end else if (key_win[K_FIRE]) begin
                    do_fail = 1'b1;
                end else if (key_win[K_SURE]) begin
                    if (dig_cnt_q == CW'(DIGITS) && entry_q == CODE) begin
                        state_d = S_ARMED;
`ifdef DETONATOR_LOCKOUT_EN
                        fails_d = '0;
`endif
                    end else begin
                        do_fail = 1'b1;
                    end
                end else if (key_win[K_CONFIRM]) begin
                    if (dig_cnt_q < CW'(DIGITS)) begin
                        // Slot 0 is the most significant digit.
                        for (int s = 0; s < DIGITS; s++) begin
                            if (dig_cnt_q == CW'(s)) begin
                                entry_d[(DIGITS-1-s)*DIGIT_W +: DIGIT_W] = A;
                            end
                        end
                        dig_cnt_d = dig_cnt_q + CW'(1);
                    end else begin
                        do_fail = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (key_win[K_FIRE]) begin
                    state_d = S_FIRE;
                end else if (key_win[K_WAIT]) begin
                    state_d = S_IDLE;
                end
            end
            S_FIRE: begin
                if (key_win[K_WAIT]) begin
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                if (key_win[K_SETUP]) begin
                    state_d = S_IDLE;
                end
            end
`ifdef DETONATOR_LOCKOUT_EN
            S_LOCKOUT: begin
                // The timer was loaded with LOCK_CYCLES on entry, so the
                // state holds for exactly LOCK_CYCLES cycles.
                if (lock_q <= TW'(1)) begin
                    state_d = S_IDLE;
                    lock_d  = '0;
                end else begin
                    lock_d  = lock_q - TW'(1);
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_fail) begin
`ifdef DETONATOR_LOCKOUT_EN
            if (fails_inc == 4'(MAX_TRIES)) begin
                state_d = S_LOCKOUT;
                lock_d  = TW'(LOCK_CYCLES);
                fails_d = '0;
            end else begin
                state_d = S_ERROR;
                fails_d = fails_inc;
            end
`else
            state_d = S_ERROR;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dig_cnt_q <= '0;
            entry_q   <= '0;
`ifdef DETONATOR_LOCKOUT_EN
            fails_q   <= '0;
            lock_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            dig_cnt_q <= dig_cnt_d;
            entry_q   <= entry_d;
`ifdef DETONATOR_LOCKOUT_EN
            fails_q   <= fails_d;
            lock_q    <= lock_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs: lamps decoded straight from the state register.
    // ------------------------------------------------------------------
    assign state   = state_q;
    assign dig_cnt = dig_cnt_q;
    assign entry   = entry_q;
    assign lt      = (state_q == S_ARMED);
    assign rt      = (state_q == S_FIRE);

`ifdef DETONATOR_LOCKOUT_EN
    assign bt      = (state_q == S_ERROR) || (state_q == S_LOCKOUT);
    assign fails   = fails_q;
`else
    assign bt      = (state_q == S_ERROR);
    assign fails   = 4'd0;

    // The try limit and lockout length are meaningless without lockout.
    logic [31:0] unused_cfg;
    assign unused_cfg = MAX_TRIES ^ LOCK_CYCLES;
`endif

endmodule

// File: tb/tb_detonator_ctrl_n.sv
// Directed bench for detonator_ctrl_n with default parameters.
module tb_detonator_ctrl_n;

    localparam logic [5:0] P_SETUP = 6'b000001;
    localparam logic [5:0] P_WAIT  = 6'b000010;
    localparam logic [5:0] P_FIRE  = 6'b000100;
    localparam logic [5:0] P_SURE  = 6'b001000;
    localparam logic [5:0] P_CONF  = 6'b010000;
    localparam logic [5:0] P_READY = 6'b100000;

    logic        clk;
    logic        rst;
    logic [5:0]  kb;
    logic [3:0]  a_sw;
    logic        lt, bt, rt;
    logic [2:0]  state;
    logic [2:0]  dig_cnt;
    logic [15:0] entry;
    logic [3:0]  fails;

    int checks;
    int failures;

    detonator_ctrl_n dut (
        .clk     (clk),
        .rst     (rst),
        .wait_t  (kb[1]),
        .setup   (kb[0]),
        .ready   (kb[5]),
        .fire    (kb[2]),
        .sure    (kb[3]),
        .confirm (kb[4]),
        .A       (a_sw),
        .lt      (lt),
        .bt      (bt),
        .rt      (rt),
        .state   (state),
        .dig_cnt (dig_cnt),
        .entry   (entry),
        .fails   (fails)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected fail count: the counter only exists in the lockout build.
    function automatic int ef(input int n);
`ifdef DETONATOR_LOCKOUT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the key mask for 'hold' edges, release it, then take one more edge.
    // With hold >= 4, the resulting state change is visible on return.
    task automatic press(input logic [5:0] m, input int hold);
        kb = m;
        repeat (hold) tick();
        kb = '0;
        tick();
    endtask

    task automatic dig(input logic [3:0] d);
        a_sw = d;
        press(P_CONF, 4);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        kb       = '0;
        a_sw     = '0;
        repeat (2) tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_lt", 32'(lt), 0);
        chk("rst_bt", 32'(bt), 0);
        chk("rst_rt", 32'(rt), 0);
        chk("rst_dig_cnt", 32'(dig_cnt), 0);
        chk("rst_entry", 32'(entry), 0);
        chk("rst_fails", 32'(fails), 0);
        rst = 1'b0;
        tick();

        // Debounce: a 1-cycle blip and a 3-cycle press must not register.
        kb = P_READY; tick();
        kb = '0;      tick();
        kb = P_READY; repeat (3) tick();
        kb = '0;      repeat (2) tick();
        chk("glitch_no_move", 32'(state), 0);
        press(P_READY, 4);
        chk("ready4_entry", 32'(state), 1);
        press(P_WAIT, 4);
        chk("wait_to_idle", 32'(state), 0);
        press(P_READY, 20);
        chk("ready20_entry", 32'(state), 1);
        chk("ready20_dig_cnt", 32'(dig_cnt), 0);

        // Correct code. The first confirm is held long to prove a single pulse.
        a_sw = 4'd2;
        press(P_CONF, 20);
        chk("held_conf_dig_cnt", 32'(dig_cnt), 1);
        chk("held_conf_entry", 32'(entry), 32'h2000);
        dig(4'd5); dig(4'd8); dig(4'd0);
        chk("code_entry", 32'(entry), 32'h2580);
        chk("code_dig_cnt", 32'(dig_cnt), 4);
        press(P_SURE, 4);
        chk("sure_armed", 32'(state), 2);
        chk("armed_lt", 32'(lt), 1);
        press(P_FIRE, 4);
        chk("fire_state", 32'(state), 3);
        chk("fire_rt", 32'(rt), 1);
        chk("fire_lt_off", 32'(lt), 0);
        press(P_WAIT, 4);
        chk("fire_wait_idle", 32'(state), 0);
        chk("entry_held_idle", 32'(entry), 32'h2580);

        // Early fire.
        press(P_READY, 4);
        chk("ready_clr_entry", 32'(entry), 0);
        chk("ready_clr_cnt", 32'(dig_cnt), 0);
        dig(4'd2);
        press(P_FIRE, 4);
        chk("early_fire_err", 32'(state), 4);
        chk("early_fire_bt", 32'(bt), 1);
        chk("early_fire_fails", 32'(fails), 32'(ef(1)));
        press(P_WAIT, 4);
        chk("err_wait_ignored", 32'(state), 4);
        press(P_SETUP, 4);
        chk("err_setup_idle", 32'(state), 0);

        // Short code.
        press(P_READY, 4);
        dig(4'd2);
        press(P_SURE, 4);
        chk("short_err", 32'(state), 4);
        chk("short_fails", 32'(fails), 32'(ef(2)));
        press(P_SETUP, 4);

        // Over-entry: fifth confirm fails; in the lockout build it is the third fail.
        press(P_READY, 4);
        dig(4'd1); dig(4'd2); dig(4'd3); dig(4'd4);
        chk("four_dig_cnt", 32'(dig_cnt), 4);
        chk("four_state", 32'(state), 1);
        dig(4'd5);
`ifdef DETONATOR_LOCKOUT_EN
        chk("lock_state", 32'(state), 5);
        chk("lock_bt", 32'(bt), 1);
        chk("lock_fails", 32'(fails), 0);
        press(P_READY, 4);          // 5 cycles into lockout
        chk("lock_ignore_ready", 32'(state), 5);
        repeat (10) tick();         // 15 cycles in lockout
        chk("lock_last_cycle", 32'(state), 5);
        tick();                     // 16th cycle done
        chk("lock_expire_idle", 32'(state), 0);
`else
        chk("over_err", 32'(state), 4);
        chk("over_fails", 32'(fails), 0);
        press(P_SETUP, 4);
        chk("over_setup_idle", 32'(state), 0);
`endif

        // Wrong code of full length.
        press(P_READY, 4);
        dig(4'd3); dig(4'd2); dig(4'd8); dig(4'd1);
        press(P_SURE, 4);
        chk("wrong_err", 32'(state), 4);
        chk("wrong_fails", 32'(fails), 32'(ef(1)));
        press(P_SETUP, 4);

        // Priority: setup beats fire, wait_t beats fire.
        press(P_READY, 4);
        press(P_SETUP | P_FIRE, 4);
        chk("prio_setup_fire", 32'(state), 1);
        chk("prio_fails_same", 32'(fails), 32'(ef(1)));
        press(P_WAIT | P_FIRE, 4);
        chk("prio_wait_fire", 32'(state), 0);

        // Success clears fails, then reset from ARMED with ready held through it.
        press(P_READY, 4);
        dig(4'd2); dig(4'd5); dig(4'd8); dig(4'd0);
        press(P_SURE, 4);
        chk("armed_again", 32'(state), 2);
        chk("success_clr_fails", 32'(fails), 0);
        rst = 1'b1;
        kb  = P_READY;
        tick();
        chk("midrst_state", 32'(state), 0);
        chk("midrst_lt", 32'(lt), 0);
        chk("midrst_entry", 32'(entry), 0);
        chk("midrst_dig_cnt", 32'(dig_cnt), 0);
        rst = 1'b0;
        repeat (4) tick();
        chk("post_rst_debounce", 32'(state), 0);
        tick();
        chk("post_rst_pulse", 32'(state), 1);
        kb = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
